// File: rtl/tank_game_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : tank_game_pkg
//  Description: Shared state encoding, player id, keyboard constants and
//               small helpers for the turn-based tank game.
//  Revision   : 1.0 - initial release
// ============================================================================
package tank_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TURN     = 3'd1,
        ST_FLIGHT   = 3'd2,
        ST_RESOLVE  = 3'd3,
        ST_SWITCH   = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_t;

    typedef enum logic {
        PLAYER_A = 1'b0,
        PLAYER_B = 1'b1
    } player_t;

    localparam logic [7:0] C_KEY_A_LEFT  = 8'h04;
    localparam logic [7:0] C_KEY_A_RIGHT = 8'h07;
    localparam logic [7:0] C_KEY_B_LEFT  = 8'h0D;
    localparam logic [7:0] C_KEY_B_RIGHT = 8'h0F;
    localparam logic [7:0] C_KEY_SPACE   = 8'h2C;
    localparam logic [7:0] C_KEY_ESC     = 8'h29;

    // True when the key is one of the movement keys owned by the given player
    function automatic logic is_move_key(input player_t p, input logic [7:0] k);
        if (p == PLAYER_A)
            return (k == C_KEY_A_LEFT) || (k == C_KEY_A_RIGHT);
        else
            return (k == C_KEY_B_LEFT) || (k == C_KEY_B_RIGHT);
    endfunction

    // Unsigned 4-bit subtraction that floors at zero instead of wrapping
    function automatic logic [3:0] hp_sub_sat(input logic [3:0] hp, input logic [3:0] dmg);
        return (hp > dmg) ? (hp - dmg) : 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turn_controller_if.sv
`default_nettype none
// ============================================================================
//  Interface  : turn_controller_if
//  Description: Keyboard / projectile / status bundle between the game
//               fabric (master) and the turn controller (slave).
//  Revision   : 1.0 - initial release
// ============================================================================
interface turn_controller_if;

    logic [7:0] keycode;
    logic       shot_fired;
    logic       proj_done;
    logic       proj_hit;
    logic [7:0] keycode_A;
    logic [7:0] keycode_B;
    logic       active_player;
    logic [3:0] hp_A;
    logic [3:0] hp_B;
    logic [7:0] moves_left;
    logic       game_over;
    logic       winner;

    modport master (
        output keycode, shot_fired, proj_done, proj_hit,
        input  keycode_A, keycode_B, active_player, hp_A, hp_B,
               moves_left, game_over, winner
    );

    modport slave (
        input  keycode, shot_fired, proj_done, proj_hit,
        output keycode_A, keycode_B, active_player, hp_A, hp_B,
               moves_left, game_over, winner
    );

endinterface
`default_nettype wire

// File: rtl/turn_controller_timer.sv
`default_nettype none
// ============================================================================
//  Module     : turn_timer
//  Description: 10-bit frame counter with synchronous clear, count enable and
//               a terminal-count flag at TURN_TIMEOUT-1.
//  Revision   : 1.0 - initial release
// ============================================================================
module turn_timer #(
    parameter int TURN_TIMEOUT = 600
) (
    input  wire logic frame_clk,
    input  wire logic Reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_tc
);

    localparam logic [9:0] C_TC_VALUE = 10'(TURN_TIMEOUT - 1);

    logic [9:0] r_count;

    // Clear wins over enable so a turn always starts from zero
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            r_count <= 10'd0;
        else if (i_clear)
            r_count <= 10'd0;
        else if (i_enable)
            r_count <= r_count + 10'd1;
    end

    assign o_tc = (r_count == C_TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/turn_controller.sv
`default_nettype none
// ============================================================================
//  Module     : turn_controller
//  Description: Turn sequencing for a two-tank artillery game: gates keyboard
//               input to the active tank, budgets movement, tracks shell
//               flight, applies damage and detects the end of the game.
//  Revision   : 1.0 - initial release
// ============================================================================
module turn_controller
    import tank_game_pkg::*;
#(
    parameter int MOVE_BUDGET  = 120,
    parameter int TURN_TIMEOUT = 600,
    parameter int HIT_DAMAGE   = 2,
    parameter int INIT_HP      = 10
) (
    input  wire logic         frame_clk,
    input  wire logic         Reset,
    turn_controller_if.slave  bus
);

    localparam logic [7:0] C_MOVES = 8'(MOVE_BUDGET);
    localparam logic [3:0] C_HP    = 4'(INIT_HP);
    localparam logic [3:0] C_DMG   = 4'(HIT_DAMAGE);

    state_t     r_state;
    state_t     w_state_next;
    player_t    r_active;
    logic [7:0] r_moves;
    logic [3:0] r_hp_a;
    logic [3:0] r_hp_b;
    logic       r_hit_latch;
    logic       r_winner;

    logic       w_timer_clr;
    logic       w_timer_en;
    logic       w_timer_tc;
    logic       w_move_dec;
    logic       w_is_move;
    logic [7:0] w_gated_key;
    logic [7:0] w_key_a;
    logic [7:0] w_key_b;
    logic [3:0] w_opp_hp;
    logic [3:0] w_opp_hp_new;

    turn_timer #(
        .TURN_TIMEOUT (TURN_TIMEOUT)
    ) u_turn_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_clear   (w_timer_clr),
        .i_enable  (w_timer_en),
        .o_tc      (w_timer_tc)
    );

    // An exhausted budget blanks only the active tank's movement keys
    assign w_is_move    = is_move_key(r_active, bus.keycode);
    assign w_gated_key  = (w_is_move && (r_moves == 8'd0)) ? 8'h00 : bus.keycode;

    // Opponent HP as it will be after this RESOLVE frame
    assign w_opp_hp     = (r_active == PLAYER_A) ? r_hp_b : r_hp_a;
    assign w_opp_hp_new = r_hit_latch ? hp_sub_sat(w_opp_hp, C_DMG) : w_opp_hp;

    // State register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and per-state control/key gating
    always_comb begin
        w_state_next = r_state;
        w_key_a      = 8'h00;
        w_key_b      = 8'h00;
        w_timer_clr  = 1'b0;
        w_timer_en   = 1'b0;
        w_move_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_clr = 1'b1;
                if (bus.keycode == C_KEY_SPACE)
                    w_state_next = ST_TURN;
            end
            ST_TURN: begin
                w_timer_en = 1'b1;
                if (r_active == PLAYER_A)
                    w_key_a = w_gated_key;
                else
                    w_key_b = w_gated_key;
                w_move_dec = w_is_move && (r_moves != 8'd0);
                // A shot on the timeout frame still counts as a shot
                if (bus.shot_fired)
                    w_state_next = ST_FLIGHT;
                else if (w_timer_tc)
                    w_state_next = ST_SWITCH;
            end
            ST_FLIGHT: begin
                if (bus.proj_done)
                    w_state_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                w_state_next = (w_opp_hp_new == 4'd0) ? ST_GAMEOVER : ST_SWITCH;
            end
            ST_SWITCH: begin
                w_timer_clr  = 1'b1;
                w_state_next = ST_TURN;
            end
            ST_GAMEOVER: begin
                if (bus.keycode == C_KEY_ESC)
                    w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Turn datapath: active player, move budget, hit latch, HP and winner
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_active    <= PLAYER_A;
            r_moves     <= C_MOVES;
            r_hit_latch <= 1'b0;
            r_hp_a      <= C_HP;
            r_hp_b      <= C_HP;
            r_winner    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.keycode == C_KEY_SPACE) begin
                        r_active <= PLAYER_A;
                        r_moves  <= C_MOVES;
                    end
                end
                ST_TURN: begin
                    if (w_move_dec)
                        r_moves <= r_moves - 8'd1;
                end
                ST_FLIGHT: begin
                    if (bus.proj_done)
                        r_hit_latch <= bus.proj_hit;
                end
                ST_RESOLVE: begin
                    r_hit_latch <= 1'b0;
                    if (r_hit_latch) begin
                        if (r_active == PLAYER_A)
                            r_hp_b <= w_opp_hp_new;
                        else
                            r_hp_a <= w_opp_hp_new;
                        if (w_opp_hp_new == 4'd0)
                            r_winner <= r_active;
                    end
                end
                ST_SWITCH: begin
                    r_active <= (r_active == PLAYER_A) ? PLAYER_B : PLAYER_A;
                    r_moves  <= C_MOVES;
                end
                ST_GAMEOVER: begin
                    if (bus.keycode == C_KEY_ESC) begin
                        r_hp_a <= C_HP;
                        r_hp_b <= C_HP;
                    end
                end
                default: begin
                    r_hit_latch <= 1'b0;
                end
            endcase
        end
    end

    assign bus.keycode_A     = w_key_a;
    assign bus.keycode_B     = w_key_b;
    assign bus.active_player = r_active;
    assign bus.hp_A          = r_hp_a;
    assign bus.hp_B          = r_hp_b;
    assign bus.moves_left    = r_moves;
    assign bus.game_over     = (r_state == ST_GAMEOVER);
    assign bus.winner        = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_turn_controller.sv
`default_nettype none
// ============================================================================
//  Module     : tb_turn_controller
//  Description: Directed self-checking bench for turn_controller.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_turn_controller;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    turn_controller_if bus ();

    turn_controller #(
        .MOVE_BUDGET  (120),
        .TURN_TIMEOUT (600),
        .HIT_DAMAGE   (2),
        .INIT_HP      (10)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n frames; inputs change and outputs are sampled 1 unit after the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    // Active tank A fires and the shell hits; returns after the RESOLVE frame
    task automatic a_hit();
        bus.shot_fired = 1'b1;
        tick(1);
        bus.shot_fired = 1'b0;
        bus.proj_done  = 1'b1;
        bus.proj_hit   = 1'b1;
        tick(1);
        bus.proj_done  = 1'b0;
        bus.proj_hit   = 1'b0;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.keycode    = 8'h00;
        bus.shot_fired = 1'b0;
        bus.proj_done  = 1'b0;
        bus.proj_hit   = 1'b0;
        tick(2);

        // Reset values
        check_val("rst_active",   16'(bus.active_player), 16'd0);
        check_val("rst_hp_A",     16'(bus.hp_A),          16'd10);
        check_val("rst_hp_B",     16'(bus.hp_B),          16'd10);
        check_val("rst_moves",    16'(bus.moves_left),    16'd120);
        check_val("rst_gameover", 16'(bus.game_over),     16'd0);
        check_val("rst_winner",   16'(bus.winner),        16'd0);
        Reset = 1'b0;

        bus.keycode = 8'h04;
        #1;
        check_val("idle_keyA", 16'(bus.keycode_A), 16'h00);

        // Start: A's turn
        bus.keycode = 8'h2C;
        tick(1);

        // projectile pulses outside FLIGHT are ignored
        bus.keycode   = 8'h28;
        bus.proj_done = 1'b1;
        bus.proj_hit  = 1'b1;
        tick(1);
        bus.proj_done = 1'b0;
        bus.proj_hit  = 1'b0;
        check_val("stray_done_hpB", 16'(bus.hp_B),      16'd10);
        check_val("stray_done_keyA", 16'(bus.keycode_A), 16'h28);

        // B's movement key while A is active: forwarded to A, no budget used
        bus.keycode = 8'h0F;
        tick(3);
        check_val("bkey_active", 16'(bus.active_player), 16'd0);
        check_val("bkey_keyB",   16'(bus.keycode_B),     16'h00);
        check_val("bkey_moves",  16'(bus.moves_left),    16'd120);
        check_val("bkey_keyA",   16'(bus.keycode_A),     16'h0F);

        // Exhaust the movement budget
        bus.keycode = 8'h07;
        tick(119);
        check_val("moves_119", 16'(bus.moves_left), 16'd1);
        check_val("move_keyA", 16'(bus.keycode_A),  16'h07);
        tick(1);
        check_val("moves_120", 16'(bus.moves_left), 16'd0);
        check_val("empty_keyA", 16'(bus.keycode_A), 16'h00);
        tick(5);
        check_val("moves_125", 16'(bus.moves_left), 16'd0);
        bus.keycode = 8'h28;
        #1;
        check_val("other_key_keyA", 16'(bus.keycode_A), 16'h28);

        // Shot, flight gating, hit on B
        bus.keycode    = 8'h00;
        bus.shot_fired = 1'b1;
        tick(1);
        bus.keycode    = 8'h04;
        #1;
        check_val("flight_keyA", 16'(bus.keycode_A), 16'h00);
        check_val("flight_keyB", 16'(bus.keycode_B), 16'h00);
        tick(1);                         // shot_fired still high inside FLIGHT
        bus.shot_fired = 1'b0;
        bus.keycode    = 8'h00;
        bus.proj_done  = 1'b1;
        bus.proj_hit   = 1'b1;
        tick(1);
        bus.proj_done  = 1'b0;
        bus.proj_hit   = 1'b0;
        check_val("resolve_hpB", 16'(bus.hp_B), 16'd10);
        tick(1);
        check_val("hit1_hpB",    16'(bus.hp_B),          16'd8);
        check_val("hit1_active", 16'(bus.active_player), 16'd0);
        bus.keycode = 8'h04;
        #1;
        check_val("switch_keyA", 16'(bus.keycode_A), 16'h00);
        bus.keycode = 8'h00;
        tick(1);
        check_val("b_turn_active", 16'(bus.active_player), 16'd1);
        check_val("b_turn_moves",  16'(bus.moves_left),    16'd120);
        bus.keycode = 8'h0D;
        #1;
        check_val("b_turn_keyB", 16'(bus.keycode_B), 16'h0D);
        check_val("b_turn_keyA", 16'(bus.keycode_A), 16'h00);

        // Timeout: 600 TURN frames then SWITCH
        bus.keycode = 8'h28;
        tick(599);
        check_val("tmo_599_keyB", 16'(bus.keycode_B), 16'h28);
        tick(1);
        check_val("tmo_600_keyB", 16'(bus.keycode_B), 16'h00);
        check_val("tmo_hpA",      16'(bus.hp_A),      16'd10);
        check_val("tmo_hpB",      16'(bus.hp_B),      16'd8);
        bus.keycode = 8'h00;
        tick(1);
        check_val("tmo_active", 16'(bus.active_player), 16'd0);

        // shot_fired on the timeout frame goes to FLIGHT
        tick(599);
        bus.shot_fired = 1'b1;
        tick(1);
        bus.shot_fired = 1'b0;
        tick(1);
        check_val("shot_vs_tmo_active", 16'(bus.active_player), 16'd0);
        bus.proj_done = 1'b1;
        bus.proj_hit  = 1'b1;
        tick(1);
        bus.proj_done = 1'b0;
        bus.proj_hit  = 1'b0;
        tick(1);
        check_val("hit2_hpB", 16'(bus.hp_B), 16'd6);
        tick(1);
        tick(601);                       // B forfeits
        check_val("forfeit_active", 16'(bus.active_player), 16'd0);

        a_hit();
        check_val("hit3_hpB", 16'(bus.hp_B), 16'd4);
        tick(1);
        tick(601);
        a_hit();
        check_val("hit4_hpB", 16'(bus.hp_B), 16'd2);
        tick(1);
        tick(601);
        a_hit();
        check_val("hit5_hpB",     16'(bus.hp_B),      16'd0);
        check_val("hit5_hpA",     16'(bus.hp_A),      16'd10);
        check_val("go_gameover",  16'(bus.game_over), 16'd1);
        check_val("go_winner",    16'(bus.winner),    16'd0);
        bus.keycode = 8'h04;
        #1;
        check_val("go_keyA", 16'(bus.keycode_A), 16'h00);
        tick(1);
        check_val("go_hold", 16'(bus.game_over), 16'd1);

        // Esc restarts
        bus.keycode = 8'h29;
        tick(1);
        check_val("esc_gameover", 16'(bus.game_over), 16'd0);
        check_val("esc_hpA",      16'(bus.hp_A),      16'd10);
        check_val("esc_hpB",      16'(bus.hp_B),      16'd10);
        bus.keycode = 8'h28;
        #1;
        check_val("esc_idle_keyA", 16'(bus.keycode_A), 16'h00);

        // Reset during FLIGHT abandons the turn
        bus.keycode = 8'h2C;
        tick(1);
        bus.keycode = 8'h04;
        tick(1);
        check_val("r2_moves", 16'(bus.moves_left), 16'd119);
        bus.keycode    = 8'h00;
        bus.shot_fired = 1'b1;
        tick(1);
        bus.shot_fired = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check_val("async_rst_moves",  16'(bus.moves_left),    16'd120);
        check_val("async_rst_active", 16'(bus.active_player), 16'd0);
        check_val("async_rst_go",     16'(bus.game_over),     16'd0);
        tick(1);
        Reset = 1'b0;
        bus.proj_done = 1'b1;
        bus.proj_hit  = 1'b1;
        tick(1);
        bus.proj_done = 1'b0;
        bus.proj_hit  = 1'b0;
        tick(2);
        check_val("late_done_hpB", 16'(bus.hp_B), 16'd10);
        check_val("late_done_hpA", 16'(bus.hp_A), 16'd10);
        bus.keycode = 8'h28;
        #1;
        check_val("late_done_keyA", 16'(bus.keycode_A), 16'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameter MOVE_BUDGET, default 120, movement frames allowed per turn (8-bit range).
REQ-002 SHALL have parameter TURN_TIMEOUT, default 600, frames in TURN before forfeit (10-bit range).
REQ-003 SHALL have parameter HIT_DAMAGE, default 2, HP removed per hit.
REQ-004 SHALL have parameter INIT_HP, default 10, starting HP per tank.
REQ-005 SHALL have ports, clock and reset first:
- frame_clk  in  1  frame clock.
- Reset  in  1  reset; asynchronous, active-high.
- keycode  in  8  raw keyboard code.
- shot_fired  in  1  one-frame pulse; active tank launched a shell.
- proj_done  in  1  one-frame pulse; shell landed or left the screen.
- proj_hit  in  1  qualifies proj_done; shell struck the opponent.
- keycode_A  out  8  gated keycode to tank A.
- keycode_B  out  8  gated keycode to tank B.
- active_player  out  1  0 = A, 1 = B.
- hp_A  out  4  tank A HP.
- hp_B  out  4  tank B HP.
- moves_left  out  8  remaining movement frames.
- game_over  out  1  high in GAMEOVER.
- winner  out  1  valid while game_over; 0 = A, 1 = B.

Function
REQ-006 SHALL implement FSM states IDLE, TURN, FLIGHT, RESOLVE, SWITCH, GAMEOVER, with one transition evaluated per frame_clk.
REQ-007 IDLE SHALL go to TURN on keycode 8'h2C (space), with active_player = 0, moves_left = MOVE_BUDGET and timer = 0.
REQ-008 In TURN, the active tank's keycode output SHALL equal keycode combinationally, and the inactive tank's output SHALL be 8'h00.
REQ-009 Movement keys SHALL be 8'h04/8'h07 for A and 8'h0D/8'h0F for B; each TURN frame with an active movement key and moves_left > 0 SHALL decrement moves_left by 1.
REQ-010 When moves_left == 0, active movement keys SHALL be forwarded as 8'h00; all other keys SHALL pass unchanged.
REQ-011 TURN SHALL increment the timer every frame; shot_fired SHALL move to FLIGHT; timer == TURN_TIMEOUT-1 without shot_fired SHALL move to SWITCH (forfeit).
REQ-012 If shot_fired and timeout occur in the same frame, shot_fired SHALL win.
REQ-013 In FLIGHT, both keycode outputs SHALL be 8'h00; proj_done SHALL move to RESOLVE, latching proj_hit; shot_fired SHALL be ignored.
REQ-014 proj_done and proj_hit outside FLIGHT SHALL be ignored.
REQ-015 RESOLVE SHALL last one frame and, on a latched hit, subtract HIT_DAMAGE from the opponent's HP, saturating at 0.
REQ-016 After RESOLVE, the next state SHALL be GAMEOVER if opponent HP == 0, else SWITCH.
REQ-017 SWITCH SHALL last one frame, toggle active_player, reload moves_left = MOVE_BUDGET, clear the timer, and go to TURN.
REQ-018 GAMEOVER SHALL hold game_over = 1, winner = the player who dealt the last hit, and keycode outputs 8'h00.
REQ-019 In GAMEOVER, keycode 8'h29 (Esc) SHALL restore HP to INIT_HP and go to IDLE.
REQ-020 In IDLE and SWITCH, both keycode outputs SHALL be 8'h00.
REQ-021 The timer SHALL be 10 bits; all HP arithmetic SHALL be unsigned 4-bit with no wrap below 0.

Reset
REQ-022 Reset SHALL asynchronously force: state IDLE, active_player 0, hp_A = hp_B = INIT_HP, moves_left = MOVE_BUDGET, timer 0, hit latch 0, game_over 0, winner 0.
REQ-023 Reset asserted mid-FLIGHT or mid-TURN SHALL abandon the turn with no HP change.

Structure
REQ-024 State enum, key constants (8'h04, 8'h07, 8'h0D, 8'h0F, 8'h2C, 8'h29) and the player-id typedef SHALL live in shared package tank_game_pkg.
REQ-025 The frame timer with clear/enable/terminal-count output SHALL be a sub-module named turn_timer.

Verification
REQ-026 Reset, keycode 8'h2C, then 8'h0F for 3 frames -> active_player 0, keycode_B = 8'h00, moves_left unchanged at 120, keycode_A = 8'h0F.
REQ-027 Hold 8'h07 for 125 frames -> moves_left reaches 0 at frame 120, then keycode_A = 8'h00 while 8'h28 still passes.
REQ-028 shot_fired, then proj_done with proj_hit = 1 -> hp_B goes 10 -> 8 after RESOLVE, then active_player = 1 and moves_left = 120.
REQ-029 No shot for 600 TURN frames -> SWITCH at frame 600 with HP unchanged; shot_fired and timeout in the same frame -> FLIGHT.
REQ-030 Five consecutive A hits with B forfeiting in between -> hp_B = 0, game_over = 1, winner = 0; Esc -> IDLE with hp = 10.
REQ-031 Reset pulse during FLIGHT -> IDLE, all outputs at reset values, and a later proj_done is ignored.
